// File: rtl/iram_multiport.sv
// Multi-port instruction RAM: a loader fills the array in LOAD state, then NUM_CORES
// independent fetch ports read it with 1-cycle latency in RUN state.
module iram_multiport #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 16,
  parameter int                 DEPTH     = 1024,
  parameter int                 NUM_CORES = 4,
  parameter logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(32'd41)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          load_start,
  input  logic                          load_done,
  output logic                          wr_err,
  output logic                          running,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  output logic [NUM_CORES-1:0]          rsp_valid,
  output logic [NUM_CORES*DATA_W-1:0]   rsp_data,
  output logic [NUM_CORES-1:0]          addr_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   running_r;
  logic                   wr_err_r;
  logic                   wr_ok_s;
  logic                   wr_in_range_s;

  logic [DATA_W-1:0]      mem_r      [DEPTH];
  logic [ADDR_W-1:0]      addr_s     [NUM_CORES];
  logic [NUM_CORES-1:0]   in_range_s;
  logic [NUM_CORES-1:0]   accept_s;
  logic [DATA_W-1:0]      rd_word_s  [NUM_CORES];
  logic [DATA_W-1:0]      rsp_data_r [NUM_CORES];
  logic [NUM_CORES-1:0]   rsp_valid_r;
  logic [NUM_CORES-1:0]   addr_err_r;

  // Next-state logic: load_done wins in LOAD, load_start wins in RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_LOAD:  state_nxt_s = load_done  ? S_RUN  : S_LOAD;
      S_RUN:   state_nxt_s = load_start ? S_LOAD : S_RUN;
      default: state_nxt_s = S_LOAD;
    endcase
  end

  // State register with the running flag tracking the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_LOAD;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == S_RUN);
    end
  end

  // Load-port qualification.
  always_comb begin
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    wr_ok_s       = (state_r == S_LOAD) & wr_en & wr_in_range_s;
  end

  // Rejected-write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_en & ~wr_ok_s;
    end
  end

  // Storage array; contents survive reset on purpose so a core reset keeps the program.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Per-core address decode and read mux.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      addr_s[i]     = req_addr[i*ADDR_W +: ADDR_W];
      in_range_s[i] = ({1'b0, addr_s[i]} < DEPTH_L);
      accept_s[i]   = (state_r == S_RUN) & req_valid[i];
      rd_word_s[i]  = in_range_s[i] ? mem_r[addr_s[i][IDX_W-1:0]] : NOP_WORD;
    end
  end

  // Response registers; data holds its last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= '0;
      addr_err_r  <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        rsp_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        rsp_valid_r[i] <= accept_s[i];
        addr_err_r[i]  <= accept_s[i] & ~in_range_s[i];
        if (accept_s[i]) begin
          rsp_data_r[i] <= rd_word_s[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
    assign rsp_data[g*DATA_W +: DATA_W] = rsp_data_r[g];
  end

  assign rsp_valid = rsp_valid_r;
  assign addr_err  = addr_err_r;
  assign wr_err    = wr_err_r;
  assign running   = running_r;

endmodule

// File: tb/tb_iram_multiport.sv
// Directed vector bench for iram_multiport: one record per clock cycle of inputs,
// with the registered outputs expected right after that cycle's rising edge.
module tb_iram_multiport;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_data;
  logic         load_start;
  logic         load_done;
  logic         wr_err;
  logic         running;
  logic [3:0]   req_valid;
  logic [63:0]  req_addr;
  logic [3:0]   rsp_valid;
  logic [63:0]  rsp_data;
  logic [3:0]   addr_err;

  int n_vec  = 0;
  int n_miss = 0;

  iram_multiport dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .load_start (load_start),
    .load_done  (load_done),
    .wr_err     (wr_err),
    .running    (running),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        ls;
    logic        ld;
    logic [3:0]  rv;
    logic [63:0] ra;
    logic        run;
    logic        werr;
    logic [3:0]  vld;
    logic [3:0]  aerr;
    logic [3:0]  dm;
    logic [63:0] d;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic add(input logic r, input logic we, input int wa, input int wd,
                     input logic ls, input logic ld, input logic [3:0] rv, input logic [63:0] ra,
                     input logic run, input logic werr, input logic [3:0] vld,
                     input logic [3:0] aerr, input logic [3:0] dm, input logic [63:0] d);
    vec_t v;
    v.r = r; v.we = we; v.wa = 16'(wa); v.wd = 16'(wd); v.ls = ls; v.ld = ld;
    v.rv = rv; v.ra = ra; v.run = run; v.werr = werr; v.vld = vld; v.aerr = aerr;
    v.dm = dm; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic cmp(input int idx, input string what, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %h, want %h", idx, what, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    load_start = v.ls; load_done = v.ld; req_valid = v.rv; req_addr = v.ra;
  endtask

  task automatic check(input int idx, input vec_t v);
    logic [63:0] m;
    for (int c = 0; c < 4; c++) m[c*16 +: 16] = {16{v.dm[c]}};
    n_vec++;
    cmp(idx, "running",   64'(running),   64'(v.run));
    cmp(idx, "wr_err",    64'(wr_err),    64'(v.werr));
    cmp(idx, "rsp_valid", 64'(rsp_valid), 64'(v.vld));
    cmp(idx, "addr_err",  64'(addr_err),  64'(v.aerr));
    cmp(idx, "rsp_data",  rsp_data & m,   v.d & m);
  endtask

  initial begin
    vec_t v;
    //   r     we    wa    wd  ls    ld    rv       ra                     run   werr  vld      aerr     dm       d
    add(1'b1, 1'b0, 0,    0,  1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(0,0,0,0));
    add(1'b0, 1'b1, 0,    45, 1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b1, 1,    5,  1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b1, 2,    16, 1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b1, 3,    40, 1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b1, 976,  11, 1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b1, 1023, 77, 1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b1, 4,    7,  1'b0, 1'b1, 4'b0000, pk(0,0,0,0),          1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b1001, pk(0,0,0,3),          1'b1, 1'b0, 4'b1001, 4'b0000, 4'b1111, pk(45,0,0,40));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b1111, pk(1,1,1,1),          1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, pk(5,5,5,5));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b1111, pk(1,1,1,1),          1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, pk(5,5,5,5));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b1111, pk(1,1,1,1),          1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, pk(5,5,5,5));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b0010, pk(0,2000,0,0),       1'b1, 1'b0, 4'b0010, 4'b0010, 4'b1111, pk(5,41,5,5));
    add(1'b0, 1'b1, 0,    99, 1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1111, pk(5,41,5,5));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b0001, pk(0,0,0,0),          1'b1, 1'b0, 4'b0001, 4'b0000, 4'b1111, pk(45,41,5,5));
    add(1'b0, 1'b0, 0,    0,  1'b1, 1'b0, 4'b0100, pk(0,0,4,0),          1'b0, 1'b0, 4'b0100, 4'b0000, 4'b1111, pk(45,41,7,5));
    add(1'b0, 1'b1, 2000, 123,1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, pk(45,41,7,5));
    add(1'b0, 1'b1, 0,    32, 1'b0, 1'b0, 4'b1111, pk(1,1,1,1),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(45,41,7,5));
    add(1'b0, 1'b0, 0,    0,  1'b1, 1'b1, 4'b0000, pk(0,0,0,0),          1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(45,41,7,5));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b1111, pk(0,1,976,3),        1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, pk(32,5,11,40));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b0011, pk(1023,1024,0,0),    1'b1, 1'b0, 4'b0011, 4'b0010, 4'b1111, pk(77,41,11,40));
    add(1'b0, 1'b0, 0,    0,  1'b1, 1'b1, 4'b0001, pk(2,0,0,0),          1'b0, 1'b0, 4'b0001, 4'b0000, 4'b1111, pk(16,41,11,40));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b1, 4'b0000, pk(0,0,0,0),          1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(16,41,11,40));
    add(1'b1, 1'b1, 0,    99, 1'b0, 1'b0, 4'b0100, pk(0,0,1,0),          1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(0,0,0,0));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b1, 4'b0000, pk(0,0,0,0),          1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(0,0,0,0));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b0101, pk(0,0,1,0),          1'b1, 1'b0, 4'b0101, 4'b0000, 4'b1111, pk(32,0,5,0));
    add(1'b0, 1'b0, 0,    0,  1'b0, 1'b0, 4'b0000, pk(0,0,0,0),          1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, pk(32,0,5,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check(i, vecs[i]);
      @(negedge clk);
    end

    // Held wr_en in RUN: wr_err is asserted for each rejected cycle, then clears.
    v = vecs[vecs.size() - 1];
    v.we = 1'b1; v.wa = 16'd2; v.wd = 16'd500;
    v.werr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(v);
      @(posedge clk);
      #1;
      check(100 + k, v);
      @(negedge clk);
    end
    v.we = 1'b0; v.werr = 1'b0; v.rv = 4'b1000; v.ra = pk(0,0,0,2);
    v.vld = 4'b1000; v.d = pk(32,0,5,16);
    drive(v);
    @(posedge clk);
    #1;
    check(102, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
